// File: rtl/fp_unit_arbiter.sv
// Round-robin arbiter sharing one combinational FP add/mul unit between two
// requesters; operands are held for SETTLE cycles before the result is captured.
module fp_unit_arbiter #(
  parameter int DATA_W = 8,
  parameter int SETTLE = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              req1_ready,
  output logic              resp0_valid,
  output logic [DATA_W-1:0] resp0_data,
  input  logic              resp0_ready,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp1_data,
  input  logic              resp1_ready,
  output logic              fpu_op,
  output logic [DATA_W-1:0] fpu_a,
  output logic [DATA_W-1:0] fpu_b,
  input  logic [DATA_W-1:0] fpu_result
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                       state_q;
  logic [CNT_W-1:0]             cnt_q;
  logic                         owner_q;
  logic                         last_grant_q;
  logic                         fpu_op_q;
  logic [DATA_W-1:0]            fpu_a_q;
  logic [DATA_W-1:0]            fpu_b_q;
  logic [1:0]                   resp_valid_q;
  logic [1:0][DATA_W-1:0]       resp_data_q;

  logic grant_d;
  logic idle;
  logic resp_ready_own;

  // A lone requester wins outright; a tie goes to whoever was not served last.
  always_comb begin
    grant_d = req1_valid;
    if (req0_valid && req1_valid) begin
      grant_d = ~last_grant_q;
    end
  end

  assign idle           = (state_q == IDLE);
  assign req0_ready     = idle && !grant_d && req0_valid;
  assign req1_ready     = idle && grant_d && req1_valid;
  assign resp_ready_own = owner_q ? resp1_ready : resp0_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      fpu_op_q     <= 1'b0;
      fpu_a_q      <= '0;
      fpu_b_q      <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (req0_ready || req1_ready) begin
            fpu_op_q     <= grant_d ? req1_op : req0_op;
            fpu_a_q      <= grant_d ? req1_a : req0_a;
            fpu_b_q      <= grant_d ? req1_b : req0_b;
            owner_q      <= grant_d;
            last_grant_q <= grant_d;
            cnt_q        <= CNT_W'(SETTLE - 1);
            state_q      <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q == '0) begin
            resp_data_q[owner_q]  <= fpu_result;
            resp_valid_q[owner_q] <= 1'b1;
            state_q               <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          if (resp_valid_q[owner_q] && resp_ready_own) begin
            resp_valid_q[owner_q] <= 1'b0;
            state_q               <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign fpu_op      = fpu_op_q;
  assign fpu_a       = fpu_a_q;
  assign fpu_b       = fpu_b_q;
  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_data  = resp_data_q[0];
  assign resp1_data  = resp_data_q[1];

endmodule

// File: tb/tb_fp_unit_arbiter.sv
// Bench for fp_unit_arbiter: directed scenarios plus random traffic, every cycle
// compared against a transaction-timing model of the arbiter.
module tb_fp_unit_arbiter;
  localparam int DW = 8;
  localparam int ST = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req0_op, req0_ready;
  logic [DW-1:0] req0_a, req0_b;
  logic          req1_valid, req1_op, req1_ready;
  logic [DW-1:0] req1_a, req1_b;
  logic          resp0_valid, resp0_ready, resp1_valid, resp1_ready;
  logic [DW-1:0] resp0_data, resp1_data;
  logic          fpu_op;
  logic [DW-1:0] fpu_a, fpu_b, fpu_result;

  logic          s1_req0_valid, s1_req0_ready, s1_req1_ready;
  logic [DW-1:0] s1_req0_a;
  logic          s1_resp0_valid, s1_resp1_valid, s1_fpu_op;
  logic [DW-1:0] s1_resp0_data, s1_resp1_data, s1_fpu_a, s1_fpu_b, s1_fpu_result;

  always #5 clk = ~clk;

  // Stand-in for the shared arithmetic unit.
  assign fpu_result    = fpu_op ? (fpu_a ^ fpu_b) : DW'(fpu_a + fpu_b);
  assign s1_fpu_result = s1_fpu_op ? (s1_fpu_a ^ s1_fpu_b) : DW'(s1_fpu_a + s1_fpu_b);

  fp_unit_arbiter #(.DATA_W(DW), .SETTLE(ST)) u_dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ready(req1_ready),
    .resp0_valid(resp0_valid), .resp0_data(resp0_data), .resp0_ready(resp0_ready),
    .resp1_valid(resp1_valid), .resp1_data(resp1_data), .resp1_ready(resp1_ready),
    .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_result(fpu_result)
  );

  fp_unit_arbiter #(.DATA_W(DW), .SETTLE(1)) u_dut_s1 (
    .clk(clk), .reset(reset),
    .req0_valid(s1_req0_valid), .req0_op(1'b0), .req0_a(s1_req0_a), .req0_b(8'h10),
    .req0_ready(s1_req0_ready),
    .req1_valid(1'b0), .req1_op(1'b0), .req1_a(8'h00), .req1_b(8'h00),
    .req1_ready(s1_req1_ready),
    .resp0_valid(s1_resp0_valid), .resp0_data(s1_resp0_data), .resp0_ready(1'b1),
    .resp1_valid(s1_resp1_valid), .resp1_data(s1_resp1_data), .resp1_ready(1'b1),
    .fpu_op(s1_fpu_op), .fpu_a(s1_fpu_a), .fpu_b(s1_fpu_b), .fpu_result(s1_fpu_result)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] ref_fpu(input bit op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    return op ? (a ^ b) : DW'(a + b);
  endfunction

  // Model: one job in flight, result visible from accept edge + ST until consumed.
  bit            m_busy, m_own, m_last, m_fop;
  int            m_acc;
  logic [DW-1:0] m_res, m_fa, m_fb;
  int            cyc;
  int            pend0, pend1;
  bit            rnd_mode;
  bit            hs0, hs1;
  int            grant_log[$];
  logic [DW-1:0] res_log0[$];
  logic [DW-1:0] res_log1[$];

  task automatic model_reset();
    m_busy = 0; m_own = 0; m_last = 1; m_fop = 0; m_fa = '0; m_fb = '0;
  endtask

  task automatic clear_logs();
    grant_log.delete(); res_log0.delete(); res_log1.delete();
  endtask

  task automatic step();
    bit w, e_r0, e_r1, e_v0, e_v1, done;
    @(negedge clk);
    w    = (req0_valid && req1_valid) ? ~m_last : req1_valid;
    e_r0 = !m_busy && req0_valid && !w;
    e_r1 = !m_busy && req1_valid && w;
    done = m_busy && (cyc >= m_acc + ST);
    e_v0 = done && !m_own;
    e_v1 = done && m_own;
    check_eq("req0_ready", req0_ready, e_r0);
    check_eq("req1_ready", req1_ready, e_r1);
    check_eq("resp0_valid", resp0_valid, e_v0);
    check_eq("resp1_valid", resp1_valid, e_v1);
    if (e_v0) check_eq("resp0_data", resp0_data, m_res);
    if (e_v1) check_eq("resp1_data", resp1_data, m_res);
    check_eq("fpu_op", fpu_op, m_fop);
    check_eq("fpu_a", fpu_a, m_fa);
    check_eq("fpu_b", fpu_b, m_fb);
    hs0 = req0_valid && req0_ready && !reset;
    hs1 = req1_valid && req1_ready && !reset;
    if (hs0) grant_log.push_back(0);
    if (hs1) grant_log.push_back(1);
    if (resp0_valid && resp0_ready && !reset) res_log0.push_back(resp0_data);
    if (resp1_valid && resp1_ready && !reset) res_log1.push_back(resp1_data);
    if (reset) begin
      model_reset();
    end else if (m_busy) begin
      if (done && (m_own ? resp1_ready : resp0_ready)) m_busy = 0;
    end else if (e_r0 || e_r1) begin
      m_busy = 1; m_own = e_r1; m_last = e_r1; m_acc = cyc + 1;
      m_fop  = e_r1 ? req1_op : req0_op;
      m_fa   = e_r1 ? req1_a : req0_a;
      m_fb   = e_r1 ? req1_b : req0_b;
      m_res  = ref_fpu(m_fop, m_fa, m_fb);
    end
    @(posedge clk);
    cyc++;
    #1;
    if (hs0) begin pend0--; if (pend0 <= 0) req0_valid = 0; end
    if (hs1) begin pend1--; if (pend1 <= 0) req1_valid = 0; end
    if (rnd_mode) begin
      if (!req0_valid && $urandom_range(0, 2) == 0) begin
        req0_op = 1'($urandom_range(0, 1)); req0_a = DW'($urandom()); req0_b = DW'($urandom());
        pend0 = 1; req0_valid = 1;
      end
      if (!req1_valid && $urandom_range(0, 2) == 0) begin
        req1_op = 1'($urandom_range(0, 1)); req1_a = DW'($urandom()); req1_b = DW'($urandom());
        pend1 = 1; req1_valid = 1;
      end
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_until(input int nres, input int maxc, input string tag);
    int c = 0;
    while ((res_log0.size() + res_log1.size()) < nres && c < maxc) begin
      step();
      c++;
    end
    check_eq(tag, res_log0.size() + res_log1.size(), nres);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int last_acc, last_v, nres, issued;
    int acc_q[$];
    logic [DW-1:0] s1_exp[$];

    req0_valid = 0; req0_op = 0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_op = 0; req1_a = '0; req1_b = '0;
    resp0_ready = 1; resp1_ready = 1;
    s1_req0_valid = 0; s1_req0_a = '0;
    pend0 = 0; pend1 = 0; rnd_mode = 0; cyc = 0;
    reset = 1;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    model_reset();
    check_eq("reset fpu_a", fpu_a, 0);
    check_eq("reset fpu_op", fpu_op, 0);
    check_eq("reset resp0_data", resp0_data, 0);
    check_eq("reset resp1_data", resp1_data, 0);
    check_eq("reset resp0_valid", resp0_valid, 0);

    // T1 single add
    clear_logs();
    req0_op = 0; req0_a = 8'h70; req0_b = 8'h50; pend0 = 1; req0_valid = 1;
    run_until(1, 20, "T1 completion");
    check_eq("T1 resp0_data", res_log0.size() > 0 ? res_log0[0] : 8'h00, 8'hC0);
    check_eq("T1 resp1 count", res_log1.size(), 0);

    // T2 tie right after reset
    reset = 1; step(); reset = 0;
    clear_logs();
    req0_op = 1; req0_a = 8'hF0; req0_b = 8'h50; pend0 = 1; req0_valid = 1;
    req1_op = 0; req1_a = 8'h40; req1_b = 8'h70; pend1 = 1; req1_valid = 1;
    run_until(2, 30, "T2 completion");
    check_eq("T2 first grant", grant_log.size() > 0 ? grant_log[0] : -1, 0);
    check_eq("T2 second grant", grant_log.size() > 1 ? grant_log[1] : -1, 1);
    check_eq("T2 resp0_data", res_log0.size() > 0 ? res_log0[0] : 8'h00, 8'hA0);
    check_eq("T2 resp1_data", res_log1.size() > 0 ? res_log1[0] : 8'h00, 8'hB0);

    // T3 round robin with both held valid
    clear_logs();
    req0_op = 0; req0_a = 8'h11; req0_b = 8'h22; pend0 = 2; req0_valid = 1;
    req1_op = 1; req1_a = 8'h33; req1_b = 8'h0F; pend1 = 2; req1_valid = 1;
    run_until(4, 40, "T3 completion");
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("T3 grant %0d", i), grant_log.size() > i ? grant_log[i] : -1, i % 2);

    // T4 backpressure on requester 1
    clear_logs();
    resp1_ready = 0;
    req1_op = 1; req1_a = 8'h3C; req1_b = 8'h0F; pend1 = 1; req1_valid = 1;
    repeat (3) step();
    check_eq("T4 resp1_valid up", resp1_valid, 1);
    req0_op = 0; req0_a = 8'h12; req0_b = 8'h34; pend0 = 1; req0_valid = 1;
    repeat (5) step();
    check_eq("T4 resp1_valid held", resp1_valid, 1);
    check_eq("T4 resp1_data held", resp1_data, 8'h33);
    check_eq("T4 grants during stall", grant_log.size(), 1);
    resp1_ready = 1;
    run_until(2, 20, "T4 completion");
    check_eq("T4 resp0_data", res_log0.size() > 0 ? res_log0[0] : 8'h00, 8'h46);

    // T5 reset while the operation is settling
    clear_logs();
    req0_op = 0; req0_a = 8'h05; req0_b = 8'h06; pend0 = 1; req0_valid = 1;
    step(); step();
    reset = 1; step(); reset = 0;
    check_eq("T5 fpu_a", fpu_a, 0);
    check_eq("T5 fpu_b", fpu_b, 0);
    check_eq("T5 fpu_op", fpu_op, 0);
    check_eq("T5 resp0_valid", resp0_valid, 0);
    check_eq("T5 resp1_valid", resp1_valid, 0);
    repeat (4) step();
    check_eq("T5 aborted responses", res_log0.size() + res_log1.size(), 0);
    req1_op = 0; req1_a = 8'h01; req1_b = 8'h02; pend1 = 1; req1_valid = 1;
    run_until(1, 20, "T5 completion");
    check_eq("T5 resp1_data", res_log1.size() > 0 ? res_log1[0] : 8'h00, 8'h03);

    // Random traffic with random backpressure
    rnd_mode = 1;
    repeat (600) step();
    rnd_mode = 0;

    // T6 SETTLE=1 instance, back-to-back adds with ready tied high
    last_acc = -1; last_v = -1; nres = 0; issued = 0;
    s1_req0_a = 8'h01; s1_req0_valid = 1;
    for (int c = 0; c < 40 && nres < 3; c++) begin
      bit acc;
      @(negedge clk);
      acc = s1_req0_valid && s1_req0_ready;
      if (acc) begin
        if (last_acc >= 0) check_eq("T6 accept interval", c - last_acc, 3);
        last_acc = c;
        acc_q.push_back(c);
        s1_exp.push_back(DW'(s1_req0_a + 8'h10));
      end
      if (s1_resp0_valid) begin
        check_eq("T6 resp0_data", s1_resp0_data, s1_exp.size() > 0 ? s1_exp.pop_front() : 8'hxx);
        check_eq("T6 latency", c - (acc_q.size() > 0 ? acc_q.pop_front() : -100), 2);
        if (last_v >= 0) check_eq("T6 result interval", c - last_v, 3);
        last_v = c;
        nres++;
      end
      check_eq("T6 resp1_valid", s1_resp1_valid, 0);
      @(posedge clk);
      #1;
      if (acc) begin
        issued++;
        s1_req0_a = s1_req0_a + 8'h01;
        if (issued == 3) s1_req0_valid = 0;
      end
    end
    check_eq("T6 results", nres, 3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
